// File: rtl/t05_hist_pkg.sv
// Shared types and constants for the byte-histogram controller.
// Holds the FSM state enum, the end-of-file byte and the bin count.
package t05_hist_pkg;

    localparam int         T05_BINS     = 256;
    localparam logic [7:0] T05_EOF_BYTE = 8'h1A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACC,
        ST_ACC_WR,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_RD_OUT,
        ST_DONE
    } hist_state_t;

endpackage

// File: rtl/t05_hist_ctrl_sat_inc.sv
// Saturating incrementer: o_y = i_x + 1, held at all-ones.
// Ports: i_x (value in), o_y (incremented value out), width W.
module t05_sat_inc #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    assign o_y = (&i_x) ? i_x : i_x + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/t05_hist_ctrl.sv
// Byte-histogram sequencer: clears 256 bins, counts bytes until EOF_BYTE,
// then streams every bin out over valid/ready.
// Ports: clk, nrst (async active-low); start; in_valid/in_ready/in_data
// byte source; mem_en/mem_we/mem_addr/mem_wdata/mem_rdata single-port
// count memory (read data one cycle after the strobe); out_valid/
// out_ready/out_bin/out_count record stream; total, busy, done status.
// Option: define T05_HIST_SKIP_ZERO_EN to suppress zero-count bins.
module t05_hist_ctrl
    import t05_hist_pkg::*;
#(
    parameter int         BINS     = T05_BINS,
    parameter int         CNT_W    = 32,
    parameter logic [7:0] EOF_BYTE = T05_EOF_BYTE
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [7:0]       mem_addr,
    output logic [CNT_W-1:0] mem_wdata,
    input  logic [CNT_W-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_bin,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] total,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] LAST_BIN = 8'(BINS - 1);

    hist_state_t      r_state;
    hist_state_t      w_next;
    logic [7:0]       r_ptr;
    logic [7:0]       r_addr;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_bin_inc;
    logic [CNT_W-1:0] w_total_inc;
    logic             w_last;
    logic             w_eof;

    assign w_last = (r_ptr == LAST_BIN);
    assign w_eof  = (in_data == EOF_BYTE);

    t05_sat_inc #(.W(CNT_W)) u_bin_inc (
        .i_x (mem_rdata),
        .o_y (w_bin_inc)
    );

    t05_sat_inc #(.W(CNT_W)) u_total_inc (
        .i_x (r_total),
        .o_y (w_total_inc)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (w_last) w_next = ST_ACC;
            end
            ST_ACC: begin
                if (in_valid) w_next = w_eof ? ST_RD_REQ : ST_ACC_WR;
            end
            ST_ACC_WR: w_next = ST_ACC;
            ST_RD_REQ: w_next = ST_RD_CAP;
            ST_RD_CAP: begin
`ifdef T05_HIST_SKIP_ZERO_EN
                if (mem_rdata == '0) begin
                    w_next = w_last ? ST_DONE : ST_RD_REQ;
                end else begin
                    w_next = ST_RD_OUT;
                end
`else
                w_next = ST_RD_OUT;
`endif
            end
            ST_RD_OUT: begin
                if (out_ready) w_next = w_last ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = '0;
        out_valid = 1'b0;
        out_bin   = 8'd0;
        out_count = '0;
        done      = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = r_ptr;
            end
            ST_ACC: begin
                in_ready = 1'b1;
                // EOF is consumed without touching memory.
                if (in_valid && !w_eof) begin
                    mem_en   = 1'b1;
                    mem_addr = in_data;
                end
            end
            ST_ACC_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = w_bin_inc;
            end
            ST_RD_REQ: begin
                mem_en   = 1'b1;
                mem_addr = r_ptr;
            end
            ST_RD_OUT: begin
                out_valid = 1'b1;
                out_bin   = r_ptr;
                out_count = r_count_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ptr     <= 8'd0;
            r_addr    <= 8'd0;
            r_total   <= '0;
            r_count_q <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_total <= '0;
                        r_ptr   <= 8'd0;
                    end
                end
                // Wraps back to 0 after the last bin is cleared.
                ST_CLEAR: r_ptr <= r_ptr + 8'd1;
                ST_ACC: begin
                    if (in_valid) begin
                        if (w_eof) r_ptr  <= 8'd0;
                        else       r_addr <= in_data;
                    end
                end
                ST_ACC_WR: r_total <= w_total_inc;
                ST_RD_CAP: begin
                    r_count_q <= mem_rdata;
`ifdef T05_HIST_SKIP_ZERO_EN
                    if (mem_rdata == '0 && !w_last) r_ptr <= r_ptr + 8'd1;
`endif
                end
                ST_RD_OUT: begin
                    if (out_ready && !w_last) r_ptr <= r_ptr + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign total = r_total;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_t05_hist_ctrl.sv
// Directed bench for t05_hist_ctrl: reset, clear, accumulate, readout,
// backpressure, mid-run reset and a 4-bit saturating instance.
module tb_t05_hist_ctrl;

    localparam logic [7:0] EOFB = 8'h1A;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_bin;
    logic [31:0] out_count;
    logic [31:0] total;
    logic        busy;
    logic        done;

    logic        s_start;
    logic        s_in_valid;
    logic [7:0]  s_in_data;
    logic        s_in_ready;
    logic        s_mem_en;
    logic        s_mem_we;
    logic [7:0]  s_mem_addr;
    logic [3:0]  s_mem_wdata;
    logic [3:0]  s_mem_rdata;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_bin;
    logic [3:0]  s_out_count;
    logic [3:0]  s_total;
    logic        s_busy;
    logic        s_done;

    logic [31:0] mem  [256];
    logic [3:0]  smem [256];
    int          exp_cnt [256];
    int          checks = 0;
    int          errors = 0;

    t05_hist_ctrl dut (
        .clk(clk), .nrst(nrst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_count(out_count),
        .total(total), .busy(busy), .done(done)
    );

    t05_hist_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .nrst(nrst), .start(s_start),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_bin(s_out_bin), .out_count(s_out_count),
        .total(s_total), .busy(s_busy), .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
        if (s_mem_en) begin
            if (s_mem_we) smem[s_mem_addr] <= s_mem_wdata;
            else          s_mem_rdata      <= smem[s_mem_addr];
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_bin(int from);
        int r;
`ifdef T05_HIST_SKIP_ZERO_EN
        r = 256;
        for (int b = 255; b >= from; b--) begin
            if (exp_cnt[b] != 0) r = b;
        end
`else
        r = from;
`endif
        return r;
    endfunction

    task automatic run_clear();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_total", total, 0);
        for (int i = 0; i < 256; i++) begin
            chk("clr_wr", {mem_en, mem_we, mem_addr, in_ready, busy},
                {1'b1, 1'b1, 8'(i), 1'b0, 1'b1});
            chk("clr_wdata", mem_wdata, 0);
            @(negedge clk);
        end
        chk("acc_ready", in_ready, 1);
    endtask

    task automatic send(logic [7:0] b, logic [31:0] exp_w);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        if (b != EOFB) begin
            chk("acc_rd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, b});
        end else begin
            chk("eof_nomem", mem_en, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (b != EOFB) begin
            chk("accwr_rdy", in_ready, 0);
            chk("accwr_wr", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, b});
            chk("accwr_data", mem_wdata, exp_w);
            @(negedge clk);
        end
    endtask

    task automatic readout();
        int  eb;
        int  nrec;
        int  e;
        bit  got;
        bit  stalled;
        bit  was_rec;
        bit  rec_flag;
        eb       = next_bin(0);
        nrec     = 0;
        got      = 1'b0;
        stalled  = 1'b0;
        rec_flag = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            was_rec  = rec_flag;
            rec_flag = 1'b0;
            if (done) begin
                got = 1'b1;
                chk("done_last", eb, 256);
                if (nrec > 0) chk("done_lat", was_rec, 1);
            end else if (out_valid) begin
                e = (eb < 256) ? exp_cnt[eb] : 0;
                chk("rd_bin", out_bin, eb);
                chk("rd_cnt", out_count, e);
                if (out_bin == 8'd5 && !stalled) begin
                    stalled   = 1'b1;
                    out_ready = 1'b0;
                    repeat (10) begin
                        @(negedge clk);
                        chk("bp_hold", {out_valid, out_bin, out_count},
                            {1'b1, 8'd5, 32'(exp_cnt[5])});
                    end
                    out_ready = 1'b1;
                end
                nrec++;
                rec_flag = 1'b1;
                eb = (eb >= 256) ? 256 : next_bin(eb + 1);
            end
        end
        chk("done_seen", got, 1);
        @(negedge clk);
        chk("done_pulse", {done, busy}, 0);
`ifndef T05_HIST_SKIP_ZERO_EN
        chk("bp_tested", stalled, 1);
`endif
    endtask

    initial begin
        int nz;
        bit got7;
        bit sgot;
        nrst        = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        out_ready   = 1'b0;
        s_start     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = 8'd0;
        s_out_ready = 1'b1;

        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_ctl", {in_ready, mem_en, mem_we, out_valid, busy, done},
                6'd0);
            chk("rst_data", {mem_addr, mem_wdata, out_bin, out_count}, 0);
            chk("rst_total", total, 0);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        nrst      = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", {busy, mem_en, in_ready}, 3'd0);

        run_clear();
        send(8'h41, 32'd1);
        send(8'h41, 32'd2);
        send(8'h42, 32'd1);
        send(EOFB, 32'd0);
        chk("acc_total", total, 3);
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        exp_cnt[8'h41] = 2;
        exp_cnt[8'h42] = 1;
        readout();
        chk("total_hold", total, 3);

        run_clear();
        send(8'h41, 32'd1);
        nrst = 1'b0;
        #1;
        chk("midrst", {busy, in_ready, mem_en, out_valid}, 4'd0);
        chk("midrst_total", total, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("midrst_idle", busy, 0);
        run_clear();
        send(EOFB, 32'd0);
        chk("reclr_total", total, 0);
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        readout();

        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int c = 0; c < 300 && !s_in_ready; c++) @(negedge clk);
        chk("sat_ready", s_in_ready, 1);
        repeat (17) begin
            s_in_valid = 1'b1;
            s_in_data  = 8'h07;
            @(negedge clk);
            s_in_valid = 1'b0;
            @(negedge clk);
        end
        s_in_valid = 1'b1;
        s_in_data  = EOFB;
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("sat_total", s_total, 15);
        nz   = 0;
        got7 = 1'b0;
        sgot = 1'b0;
        for (int c = 0; c < 2000 && !sgot; c++) begin
            @(negedge clk);
            if (s_done) begin
                sgot = 1'b1;
            end else if (s_out_valid) begin
                if (s_out_bin == 8'd7) begin
                    got7 = 1'b1;
                    chk("sat_bin7", s_out_count, 15);
                end else if (s_out_count != 4'd0) begin
                    nz++;
                end
            end
        end
        chk("sat_done", sgot, 1);
        chk("sat_got7", got7, 1);
        chk("sat_others", nz, 0);
        chk("sat_total_hold", s_total, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t05_hist_ctrl.md
# t05_hist_ctrl

Sequencing controller for the Huffman-front-end byte histogram. It owns a single-port 256-entry count memory and runs three phases per file. First it clears every bin. Then it accumulates one count per incoming byte with a read-modify-write, until the end-of-file byte arrives. Finally it streams every bin's count to the downstream tree builder over a valid/ready handshake. It sits between the SPI/SD byte source and the sorting/tree stage.

## Interface
- `BINS`, 256: number of bins; the address is 8 bits and `BINS` must be 256.
- `CNT_W`, 32: width of each bin count and of `total`.
- `EOF_BYTE`, 8'h1A: terminating byte value.

- `clk` input 1: system clock.
- `nrst` input 1: reset, asynchronous, active-low.
- `start` input 1: begins a run; sampled only in IDLE.
- `in_valid` input 1: source byte valid.
- `in_data` input 8: source byte.
- `in_ready` output 1: controller accepts a byte.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: write when 1, read when 0.
- `mem_addr` output 8: bin address.
- `mem_wdata` output CNT_W: write data.
- `mem_rdata` input CNT_W: read data, valid the cycle after a read strobe.
- `out_valid` output 1: bin record valid.
- `out_ready` input 1: consumer accepts the record.
- `out_bin` output 8: bin index.
- `out_count` output CNT_W: bin count.
- `total` output CNT_W: number of counted bytes (saturating).
- `busy` output 1: the controller is not in IDLE.
- `done` output 1: one-cycle pulse at the end of readout.

## Operation
- States: IDLE, CLEAR, ACC, ACC_WR, RD_REQ, RD_CAP, RD_OUT, DONE.
- **IDLE**
  - When `start`=1: `total`←0, `ptr`←0, go to CLEAR.
  - `start` in any other state is ignored.
- **CLEAR**
  - Each cycle: `mem_en`=1, `mem_we`=1, `mem_addr`=`ptr`, `mem_wdata`=0, then `ptr`++.
  - After `ptr`=255 is written, go to ACC.
- **ACC**
  - `in_ready`=1, combinational from state only.
  - Handshake with `in_data`≠`EOF_BYTE`: issue a read (`mem_en`=1, `mem_we`=0, `mem_addr`=`in_data`), latch the address, go to ACC_WR.
  - Handshake with `in_data`=`EOF_BYTE`: no memory access, byte not counted; `ptr`←0, go to RD_REQ.
- **ACC_WR**
  - `in_ready`=0.
  - Write `mem_wdata`=sat_inc(`mem_rdata`) to the latched address.
  - `total`←sat_inc(`total`), go to ACC.
- **RD_REQ**: read `ptr`, go to RD_CAP.
- **RD_CAP**: `count_q`←`mem_rdata`, go to RD_OUT.
- **RD_OUT**
  - `out_valid`=1, `out_bin`=`ptr`, `out_count`=`count_q`.
  - On handshake: if `ptr`=255 go to DONE, else `ptr`++ and go to RD_REQ.
- **DONE**: `done`=1 for one cycle, go to IDLE.
- Arithmetic: sat_inc(x) = x if x = 2^CNT_W−1, else x+1. Counts never wrap.
- Repeated identical bytes are hazard-free: the write completes in ACC_WR before the next read.
- `total` holds its value after DONE until the next accepted `start`.

## Timing
- Reset: all outputs 0, state IDLE, `ptr`=0, `count_q`=0.
- Reset mid-run: return to IDLE immediately. Memory contents are unspecified; the next run re-clears them.
- CLEAR lasts exactly 256 cycles. `in_ready` first rises 257 cycles after the `start` cycle.
- Accumulate throughput: one byte per 2 cycles.
- Readout: 3 cycles per bin with `out_ready` tied high.
- While `out_valid`=1 and `out_ready`=0, `out_bin` and `out_count` stay stable.
- `out_valid` never drops without a handshake.
- `done` asserts on the cycle after the final readout handshake.
- `busy`=0 only in IDLE.

## Configuration
- Macro: `T05_HIST_SKIP_ZERO_EN`.
- Defined: in RD_CAP, a bin whose `mem_rdata`=0 is not presented. The controller advances `ptr` and returns to RD_REQ, or goes to DONE when `ptr`=255. Zero bins never assert `out_valid`.
- Undefined: all 256 bins are presented, zeros included.

## Structure
- Package `t05_hist_pkg` holds:
  - the state enum `hist_state_t`;
  - the constant `T05_EOF_BYTE` = 8'h1A;
  - the bin-count constant 256.
- One sub-module, `t05_sat_inc`: a parameterised combinational saturating incrementer, used for both the bin count and `total`.

## Test plan
- **Reset:** hold `nrst`=0 with random inputs → all outputs 0 and `in_ready`=0; release → state stays IDLE.
- **Clear:** pulse `start` → 256 consecutive writes of 0 to addresses 0..255; `in_ready`=1 on cycle 257; `busy`=1 throughout.
- **Accumulate and readout** (macro off, `out_ready`=1): send 0x41, 0x41, 0x42, 0x1A.
  - Expect 256 records, with bin 0x41 count 2, bin 0x42 count 1, and all others 0.
  - Expect `total`=3 and a single-cycle `done`.
- **Backpressure:** hold `out_ready`=0 for 10 cycles while bin 5 is presented → `out_valid`, `out_bin`=5 and `out_count` stay stable; the transfer completes on release.
- **Saturation:** `CNT_W`=4, send 17×0x07 then 0x1A → bin 7 count 15 and `total`=15.
- **Skip-zero and reset mid-run:**
  - With `T05_HIST_SKIP_ZERO_EN` and the stream from the accumulate test → exactly 2 records, (0x41,2) then (0x42,1).
  - With `nrst` pulsed mid-ACC → IDLE; a new `start` re-clears all bins.
